// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the MM:SS countdown timer.
// Digit layout of a count word: {min_tens, min_ones, sec_tens, sec_ones}.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    localparam logic [3:0]  BCD_MAX_ONES     = 4'd9;
    localparam logic [3:0]  BCD_MAX_SEC_TENS = 4'd5;
    localparam logic [15:0] ZERO_MMSS        = 16'h0000;

    function automatic logic [3:0] clamp_digit(
        input logic [3:0] d,
        input logic [3:0] mx
    );
        return (d > mx) ? mx : d;
    endfunction

    function automatic logic [15:0] sanitise(
        input logic [7:0] m,
        input logic [7:0] s
    );
        return {clamp_digit(m[7:4], BCD_MAX_ONES),
                clamp_digit(m[3:0], BCD_MAX_ONES),
                clamp_digit(s[7:4], BCD_MAX_SEC_TENS),
                clamp_digit(s[3:0], BCD_MAX_ONES)};
    endfunction

    // Caller guarantees v != 00:00, so min tens never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = BCD_MAX_ONES;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = BCD_MAX_SEC_TENS;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = BCD_MAX_ONES;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser followed by a rising-edge detector.
// Suitable for any slow asynchronous level (divided clocks, buttons).
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic rise_pulse
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_async};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown driven by rising edges of a slow divided clock.
// FSM, 4-digit BCD down-counter and reload register.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter bit RELOAD_ON_EXPIRE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       slow_clk_in,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic       done
);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] rel;
    logic [15:0] cnt_dec;
    logic        tick;

    sync_edge_det #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_async   (slow_clk_in),
        .rise_pulse(tick)
    );

    assign cnt_dec = bcd_dec(cnt);

    // Strobes take priority over the tick; a tick sharing a strobe cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= ZERO_MMSS;
            rel   <= ZERO_MMSS;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt   <= sanitise(load_min, load_sec);
                rel   <= sanitise(load_min, load_sec);
                state <= IDLE;
            end else if (pause) begin
                if (state == RUN) state <= PAUSED;
            end else if (start) begin
                if ((state == IDLE || state == PAUSED) && cnt != ZERO_MMSS)
                    state <= RUN;
            end else if (tick && state == RUN) begin
                if (cnt_dec == ZERO_MMSS) begin
                    done <= 1'b1;
                    if (RELOAD_ON_EXPIRE) begin
                        cnt <= rel;
                    end else begin
                        cnt   <= ZERO_MMSS;
                        state <= EXPIRED;
                    end
                end else begin
                    cnt <= cnt_dec;
                end
            end
        end
    end

    assign min_bcd = cnt[15:8];
    assign sec_bcd = cnt[7:0];
    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomised and directed bench for bcd_countdown_timer, both reload modes.
// Reference model counts in plain seconds and converts to BCD for comparison.
module tb_bcd_countdown_timer;

    localparam int S = 2;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUS = 2;
    localparam int M_EXP  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       slow_clk = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] load_min = 8'h00;
    logic [7:0] load_sec = 8'h00;

    logic [7:0] min0, sec0, min1, sec1;
    logic       run0, exp0, done0, run1, exp1, done1;

    bcd_countdown_timer #(.SYNC_STAGES(S), .RELOAD_ON_EXPIRE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .slow_clk_in(slow_clk),
        .load(load), .load_min(load_min), .load_sec(load_sec),
        .start(start), .pause(pause),
        .min_bcd(min0), .sec_bcd(sec0),
        .running(run0), .expired(exp0), .done(done0)
    );

    bcd_countdown_timer #(.SYNC_STAGES(S), .RELOAD_ON_EXPIRE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .slow_clk_in(slow_clk),
        .load(load), .load_min(load_min), .load_sec(load_sec),
        .start(start), .pause(pause),
        .min_bcd(min1), .sec_bcd(sec1),
        .running(run1), .expired(exp1), .done(done1)
    );

    always #5 clk = ~clk;

    // Period 80 ns = 8 clk; edges fall 2 ns before a clk rising edge.
    initial begin
        #23;
        forever #40 slow_clk = ~slow_clk;
    end

    typedef struct {
        int st;
        int cnt;
        int rel;
        bit done;
    } model_t;

    model_t     m0 = '{0, 0, 0, 1'b0};
    model_t     m1 = '{0, 0, 0, 1'b0};
    logic [S:0] h = '0;
    logic       tk;
    int         tick_cnt = 0;

    assign tk = h[S-1] & ~h[S];

    function automatic int san_secs(input logic [7:0] m, input logic [7:0] s);
        int mt, mo, st, so;
        mt = (m[7:4] > 9) ? 9 : int'(m[7:4]);
        mo = (m[3:0] > 9) ? 9 : int'(m[3:0]);
        st = (s[7:4] > 5) ? 5 : int'(s[7:4]);
        so = (s[3:0] > 9) ? 9 : int'(s[3:0]);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic model_t step(input model_t m, input bit rl, input bit t);
        model_t n;
        n = m;
        n.done = 1'b0;
        if (load) begin
            n.cnt = san_secs(load_min, load_sec);
            n.rel = n.cnt;
            n.st  = M_IDLE;
        end else if (pause) begin
            if (m.st == M_RUN) n.st = M_PAUS;
        end else if (start) begin
            if ((m.st == M_IDLE || m.st == M_PAUS) && m.cnt != 0) n.st = M_RUN;
        end else if (t && m.st == M_RUN) begin
            n.cnt = m.cnt - 1;
            if (n.cnt == 0) begin
                n.done = 1'b1;
                if (rl) n.cnt = m.rel;
                else n.st = M_EXP;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_vec(input model_t m);
        int mn, sc;
        mn = m.cnt / 60;
        sc = m.cnt % 60;
        return {13'b0, 4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10),
                m.st == M_RUN, m.st == M_EXP, m.done};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0       <= '{0, 0, 0, 1'b0};
            m1       <= '{0, 0, 0, 1'b0};
            h        <= '0;
            tick_cnt <= 0;
        end else begin
            m0       <= step(m0, 1'b0, tk);
            m1       <= step(m1, 1'b1, tk);
            h        <= {h[S-1:0], slow_clk};
            tick_cnt <= tick_cnt + (tk ? 1 : 0);
        end
    end

    logic [31:0] act0, act1;
    assign act0 = {13'b0, min0, sec0, run0, exp0, done0};
    assign act1 = {13'b0, min1, sec1, run1, exp1, done1};

    int total = 0;
    int bad = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("model_dut0", act0, exp_vec(m0));
            check("model_dut1", act1, exp_vec(m1));
            if (done0) done0_cnt++;
            if (done1) done1_cnt++;
        end
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load_min = m;
        load_sec = s;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = tick_cnt + n;
        for (int i = 0; i < 40 * n && tick_cnt < target; i++) @(negedge clk);
        if (tick_cnt < target) check("tick_timeout", tick_cnt, target);
    endtask

    initial begin
        int d0, d1;
        fork
            compare_loop();
        join_none
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("reset_out0", act0, 32'h0);
        check("reset_out1", act1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 00:03 runs down to expiry with a single done pulse
        do_load(8'h00, 8'h03);
        d0 = done0_cnt;
        do_start();
        wait_ticks(1);
        check("t1_02", {24'b0, sec0}, 32'h02);
        wait_ticks(2);
        @(negedge clk);
        check("t1_sec00", {16'b0, min0, sec0}, 32'h0000);
        check("t1_flags", {30'b0, run0, exp0}, 32'h1);
        check("t1_done_once", done0_cnt - d0, 1);

        // borrow chain
        do_load(8'h01, 8'h00);
        do_start();
        wait_ticks(1);
        check("t2_0059", {16'b0, min0, sec0}, 32'h0059);
        wait_ticks(1);
        do_load(8'h10, 8'h00);
        do_start();
        wait_ticks(1);
        check("t2_0959", {16'b0, min0, sec0}, 32'h0959);
        wait_ticks(2);
        check("t2_0957", {16'b0, min0, sec0}, 32'h0957);

        // pause holds the count
        do_load(8'h00, 8'h10);
        do_start();
        wait_ticks(2);
        check("t3_0008", {16'b0, min0, sec0}, 32'h0008);
        do_pause();
        wait_ticks(5);
        check("t3_hold", {15'b0, min0, sec0, run0}, {15'b0, 16'h0008, 1'b0});
        do_start();
        wait_ticks(1);
        check("t3_0007", {15'b0, min0, sec0, run0}, {15'b0, 16'h0007, 1'b1});

        // sanitising, start rejected at zero
        do_load(8'hAF, 8'h7C);
        check("t4_9959", {16'b0, min0, sec0}, 32'h9959);
        do_load(8'h00, 8'h00);
        d0 = done0_cnt;
        do_start();
        wait_ticks(2);
        check("t4_idle", {31'b0, run0}, 32'h0);
        check("t4_nodone", done0_cnt - d0, 0);

        // auto-reload mode
        do_load(8'h00, 8'h02);
        d1 = done1_cnt;
        do_start();
        wait_ticks(1);
        check("t5_01", {24'b0, sec1}, 32'h01);
        wait_ticks(1);
        @(negedge clk);
        check("t5_reload", {14'b0, min1, sec1, run1, exp1}, {14'b0, 16'h0002, 2'b10});
        check("t5_done_once", done1_cnt - d1, 1);

        // load in the same cycle as a tick wins, no decrement
        do_load(8'h00, 8'h20);
        do_start();
        wait_ticks(1);
        for (int i = 0; i < 20 && !tk; i++) @(negedge clk);
        check("t6_tick_seen", {31'b0, tk}, 32'h1);
        do_load(8'h00, 8'h30);
        check("t6_load_tick", {15'b0, min0, sec0, run0}, {15'b0, 16'h0030, 1'b0});

        // async reset mid-count
        do_start();
        wait_ticks(2);
        check("t6_0028", {16'b0, min0, sec0}, 32'h0028);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async0", act0, 32'h0);
        check("t6_async1", act1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        wait_ticks(1);
        check("t6_rel_lost", {31'b0, run1}, 32'h0);

        // random strobes against the model
        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0) begin
                load_min = 8'h00;
                load_sec = 8'($urandom_range(1, 9));
            end else begin
                load_min = 8'($urandom_range(0, 255));
                load_sec = 8'($urandom_range(0, 255));
            end
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            load  = 1'b0;
            start = 1'b0;
            pause = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
